// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x3 matrix keypad scanner with debounce and key-code decode
//
// Drives KEY_ROW one row at a time, samples the synchronized KEY_COL at the end
// of each row dwell, priority-encodes a full scan into a key code and debounces
// it into press/release events.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of key_valid while held).
//
// Ports:
//   clk_1      in   1  1 kHz game clock
//   rst        in   1  asynchronous reset, active-low
//   enable     in   1  scan enable; low stops scanning and forces IDLE
//   KEY_COL    in   3  keypad columns, active-high, asynchronous to clk_1
//   KEY_ROW    out  4  one-hot row drive, active-high
//   key_code   out  4  last accepted key: 0-9, 10 '*', 11 '#', 15 none
//   key_valid  out  1  one-cycle pulse per accepted press (and per repeat)
//   key_held   out  1  accepted key still pressed
module keypad_scan #(
    parameter int ROW_DWELL    = 4,
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_SCANS = 32
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] KEY_COL,
    output logic [3:0] KEY_ROW,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int            DW         = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
    localparam logic [3:0]    DEB        = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;
    state_t state, next_state;

    logic [2:0]    col_meta, col_sync;
    logic          running;
    logic [1:0]    row_idx;
    logic [DW-1:0] dwell;
    logic          sample, scan_end;
    logic          acc_hit;
    logic [3:0]    acc_code;
    logic          row_hit;
    logic [3:0]    row_code;
    logic          scan_hit;
    logic [3:0]    scan_code;
    logic [3:0]    cand, cnt, cand_d, cnt_d, cnt_inc;
    logic          accept;
    logic          repeat_pulse;

    function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = 4'd10;
                2'd1:    code = 4'd0;
                default: code = 4'd11;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

    // The row is sampled on its last dwell cycle; the row-3 sample closes the scan.
    assign sample   = running && enable && (dwell == DWELL_LAST);
    assign scan_end = sample && (row_idx == 2'd3);

    // Lowest column of the current row wins; an earlier row already in the
    // accumulator outranks anything seen in this row.
    always_comb begin
        row_hit = |col_sync;
        if (col_sync[0])      row_code = decode(row_idx, 2'd0);
        else if (col_sync[1]) row_code = decode(row_idx, 2'd1);
        else                  row_code = decode(row_idx, 2'd2);
        scan_hit  = acc_hit | row_hit;
        scan_code = acc_hit ? acc_code : row_code;
    end

    // Column synchronizer, row/dwell counters and per-scan accumulator.
    // 'running' delays the first dwell cycle by one so a rising enable starts
    // cleanly at row 0, dwell 0 with the row actually driven.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            col_meta <= 3'b000;
            col_sync <= 3'b000;
            running  <= 1'b0;
            row_idx  <= 2'd0;
            dwell    <= '0;
            acc_hit  <= 1'b0;
            acc_code <= 4'd0;
        end else begin
            col_meta <= KEY_COL;
            col_sync <= col_meta;
            if (!enable) begin
                running  <= 1'b0;
                row_idx  <= 2'd0;
                dwell    <= '0;
                acc_hit  <= 1'b0;
                acc_code <= 4'd0;
            end else begin
                running <= 1'b1;
                if (running) begin
                    if (dwell == DWELL_LAST) begin
                        dwell   <= '0;
                        row_idx <= row_idx + 2'd1;
                        if (row_idx == 2'd3) begin
                            acc_hit  <= 1'b0;
                            acc_code <= 4'd0;
                        end else if (!acc_hit && row_hit) begin
                            acc_hit  <= 1'b1;
                            acc_code <= row_code;
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst)         state <= IDLE;
        else if (!enable) state <= IDLE;
        else              state <= next_state;
    end

    // FSM next state plus candidate/counter updates; only scan ends act.
    always_comb begin
        next_state = state;
        cand_d     = cand;
        cnt_d      = cnt;
        accept     = 1'b0;
        cnt_inc    = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (scan_hit) begin
                        cand_d = scan_code;
                        cnt_d  = 4'd1;
                        if (DEB == 4'd1) begin
                            next_state = HELD;
                            accept     = 1'b1;
                        end else begin
                            next_state = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!scan_hit) begin
                        next_state = IDLE;
                    end else if (scan_code == cand) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB) begin
                            next_state = HELD;
                            accept     = 1'b1;
                        end
                    end else begin
                        cand_d = scan_code;
                        cnt_d  = 4'd1;
                    end
                end
                HELD: begin
                    // A higher-priority key masks the held one: treat as release.
                    if (!(scan_hit && scan_code == cand)) begin
                        cnt_d      = 4'd1;
                        next_state = (DEB == 4'd1) ? IDLE : RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (scan_hit && scan_code == cand) begin
                        next_state = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB) next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Candidate, debounce counter and registered key outputs
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            cand      <= 4'd0;
            cnt       <= 4'd0;
            key_code  <= 4'd15;
            key_valid <= 1'b0;
        end else begin
            cand      <= cand_d;
            cnt       <= cnt_d;
            key_valid <= accept | repeat_pulse;
            if (accept) key_code <= cand_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);

    logic [RW-1:0] rep_cnt;

    // Counts scan ends spent in HELD; any entry to or exit from HELD clears it.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            rep_cnt <= '0;
        end else if (!enable || state != HELD || next_state != HELD) begin
            rep_cnt <= '0;
        end else if (scan_end) begin
            rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + RW'(1);
        end
    end

    assign repeat_pulse = scan_end && (state == HELD) && (next_state == HELD) &&
                          (rep_cnt == REP_LAST);
`else
    logic [31:0] unused_repeat_scans;
    assign unused_repeat_scans = REPEAT_SCANS;
    assign repeat_pulse        = 1'b0;
`endif

    // Outputs derived directly from scanner and FSM state
    always_comb begin
        KEY_ROW  = running ? (4'b0001 << row_idx) : 4'b0000;
        key_held = (state == HELD) || (state == RELEASE_CHK);
    end

endmodule
